tsoc_mem: RTL
=============

# tsoc_mem

Parametrised single-port synchronous memory for the TiniSOC, replacing the fixed-size instruction and data memories. Width, depth, read latency and byte-write granularity are configurable. After reset an internal state machine clears every word before the memory accepts requests. Instances sit beside `top` as instruction memory (read-mostly) and data memory (read/write with byte enables). Addresses are word addresses; callers divide byte addresses by `DATA_W/8`.

## Interface
- `DATA_W`, 32, data word width in bits; multiple of 8.
- `ADDR_W`, 10, word-address width.
- `DEPTH`, 1024, number of words; 1 ≤ `DEPTH` ≤ 2^`ADDR_W`.
- `READ_LAT`, 1, read latency in cycles; legal values 1 or 2.
- `CLEAR_VAL`, 0, value written to every word during the post-reset clear.

- `clock`, in, 1, sole clock; all state changes on the rising edge.
- `reset`, in, 1, asynchronous, active-high.
- `MEM_enable`, in, 1, request qualifier.
- `MEM_read`, in, 1, read request when `MEM_enable` is high.
- `MEM_write`, in, 1, write request when `MEM_enable` is high.
- `MEM_bwe`, in, `DATA_W/8`, byte write enables; bit i covers `MEMin[8i+7:8i]`.
- `MEM_address`, in, `ADDR_W`, word address.
- `MEMin`, in, `DATA_W`, write data.
- `MEMout`, out, `DATA_W`, read data; holds its last value between reads.
- `MEM_valid`, out, 1, one-cycle pulse that qualifies `MEMout`.
- `MEM_ready`, out, 1, high once the clear sequence is complete.
- `MEM_err`, out, 1, pulses for one cycle on an out-of-range access.

## Operation
- States: `S_CLEAR` and `S_READY`.
- Reset asserted (asynchronous):
  - State goes to `S_CLEAR` and the clear counter goes to 0.
  - `MEMout`=0, `MEM_valid`=0, `MEM_ready`=0, `MEM_err`=0.
  - The read pipeline is flushed.
- `S_CLEAR`:
  - Each cycle, writes `CLEAR_VAL` to word[counter], then increments the counter.
  - After the write to word `DEPTH-1`, moves to `S_READY`.
  - All requests are ignored: no write, no valid, no err.
- `S_READY`:
  - `MEM_ready`=1 and the state is held until reset.
- Request acceptance: a request is accepted when `MEM_ready & MEM_enable` and at least one of `MEM_read`/`MEM_write` is high.
- Write, in-range address: each byte with `MEM_bwe[i]`=1 is updated on the edge. `MEM_bwe`=0 writes nothing and is not an error.
- Read, in-range address: after `READ_LAT` edges, `MEMout`=word[addr] and `MEM_valid`=1 for one cycle.
- Read and write in the same cycle to the same address: the read returns the pre-write data (read-before-write). The write still takes effect.
- Out-of-range access (`MEM_address` ≥ `DEPTH`):
  - Writes are discarded.
  - A read produces `MEMout`=0 and `MEM_valid`=1 at normal latency.
  - `MEM_err` pulses in the same cycle as the response; for a write-only access, it pulses one cycle after acceptance.
- Back-to-back reads, one per cycle, are fully pipelined. Responses return in order, one per cycle.
- Reset during `S_CLEAR` or with reads in flight: in-flight responses are dropped (no valid pulses) and the clear restarts at word 0.

## Timing
- Clear duration: `MEM_ready` rises `DEPTH` edges after reset deassertion.
- Read latency is exactly `READ_LAT` edges from the acceptance edge to `MEM_valid` high.
- Write latency: data is visible to a read accepted on the following edge.
- No back-pressure: requests are accepted every cycle while `MEM_ready`=1.
- `MEMout`, `MEM_valid` and `MEM_err` are registered outputs with no combinational path from inputs.

## Structure
- Shared define file `tsoc_mem_defs.v` holds:
  - state encodings `S_CLEAR`=1'b0 and `S_READY`=1'b1;
  - the legal `READ_LAT` range;
  - the byte-lane width constant 8.
- Sub-module `tsoc_mem_rdpipe` is parametrised by `DATA_W` and `READ_LAT`. It carries {valid, err, data} through 0 or 1 extra register stages after the array read register.
- Top level contains the storage array, the byte-write logic, the clear FSM/counter and the range check.

## Test plan
- Reset, then wait with `DEPTH`=16: `MEM_ready` is 0 for 16 edges and then 1. Reading every address returns `CLEAR_VAL`.
- Write 0xDEADBEEF to address 3 with `MEM_bwe`=4'b1111, then write 0x000000AA with `MEM_bwe`=4'b0001. Reading address 3 returns 0xDEADBEAA with `MEM_valid` after `READ_LAT` cycles (check both 1 and 2).
- Issue reads of addresses 0–7 on consecutive cycles after preloading `value=addr*4`. Responses are 0,4,…,28 on consecutive cycles with no gaps.
- Same-cycle read and write of address 5 (old value 0x11, new value 0x22): the read returns 0x11 and a following read returns 0x22.
- With `DEPTH`=12 and `ADDR_W`=4, read address 14: `MEMout`=0 with `MEM_valid`=1 and `MEM_err`=1. Writing 0x55 to address 14 leaves addresses 0–11 unchanged.
- Assert reset at clear count 7 and again with two reads in flight: no `MEM_valid` pulses occur, and `MEM_ready` rises `DEPTH` edges after the final deassertion.

Source files
------------

// File: rtl/tsoc_mem_pkg.sv
// Shared definitions for the tsoc_mem parametrised memory: controller state
// encodings, the supported read-latency range and the byte-lane width.
package tsoc_mem_pkg;

    // Clear-then-serve controller states.
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    // Supported read latencies (array read register plus optional extra stage).
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // Width of one byte-write lane.
    localparam int LANE_W = 8;

    // True when a requested read latency is supported by the read pipeline.
    function automatic logic read_lat_legal(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/tsoc_mem_rdpipe.sv
// Read-response pipeline for tsoc_mem. Takes {valid, err, data} from the array
// read register and adds zero or one further register stage so the response
// appears exactly READ_LAT edges after acceptance. A write-only out-of-range
// error always appears one edge after acceptance, independent of READ_LAT,
// so it gets its own register here.
module tsoc_mem_rdpipe
    import tsoc_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wo_err,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic wo_err_q;

    // Align the write-only range error with the first post-acceptance cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wo_err_q <= 1'b0;
        end else begin
            wo_err_q <= in_wo_err;
        end
    end

    generate
        if (READ_LAT >= READ_LAT_MAX) begin : g_stage
            logic              v_q;
            logic              e_q;
            logic [DATA_W-1:0] d_q;

            // Extra response stage; data only moves with a response so MEMout holds.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    v_q <= 1'b0;
                    e_q <= 1'b0;
                    d_q <= {DATA_W{1'b0}};
                end else begin
                    v_q <= in_valid;
                    e_q <= in_valid & in_err;
                    if (in_valid) begin
                        d_q <= in_data;
                    end
                end
            end

            assign out_valid = v_q;
            assign out_err   = e_q | wo_err_q;
            assign out_data  = d_q;
        end else begin : g_direct
            assign out_valid = in_valid;
            assign out_err   = in_err | wo_err_q;
            assign out_data  = in_data;
        end
    endgenerate

endmodule

// File: rtl/tsoc_mem.sv
// Parametrised single-port synchronous memory for TiniSOC. After reset an
// internal controller writes CLEAR_VAL to every word, then raises MEM_ready
// and serves byte-masked writes and pipelined reads (read-before-write on
// same-address collisions). Out-of-range accesses are discarded and flagged.
module tsoc_mem
    import tsoc_mem_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 10,
    parameter int              DEPTH     = 1024,
    parameter int              READ_LAT  = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  MEM_enable,
    input  logic                  MEM_read,
    input  logic                  MEM_write,
    input  logic [DATA_W/8-1:0]   MEM_bwe,
    input  logic [ADDR_W-1:0]     MEM_address,
    input  logic [DATA_W-1:0]     MEMin,
    output logic [DATA_W-1:0]     MEMout,
    output logic                  MEM_valid,
    output logic                  MEM_ready,
    output logic                  MEM_err
);

    localparam int LANES = DATA_W / LANE_W;
    // Index width of the array itself; DEPTH <= 2^ADDR_W so this never exceeds ADDR_W.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH widened by one bit so DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;

    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              rd_acc;
    logic              wr_acc;
    logic              wo_oor;

    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;

    // Request decode: acceptance qualification and address range check.
    always_comb begin
        idx      = MEM_address[IDX_W-1:0];
        in_range = ({1'b0, MEM_address} < DEPTH_X);
        rd_acc   = (state == S_READY) && MEM_enable && MEM_read;
        wr_acc   = (state == S_READY) && MEM_enable && MEM_write;
        // A combined read+write reports its error with the read response instead.
        wo_oor   = wr_acc && !MEM_read && !in_range;
    end

    // Clear controller: walks the counter over every word, then parks in S_READY.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_cnt <= {IDX_W{1'b0}};
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state <= S_READY;
                    end else begin
                        clr_cnt <= clr_cnt + IDX_W'(1);
                    end
                end
                S_READY: begin
                    state <= S_READY;
                end
                default: begin
                    state   <= S_CLEAR;
                    clr_cnt <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign MEM_ready = (state == S_READY);

    // Storage array: clear writes first, then byte-masked in-range writes.
    always_ff @(posedge clock) begin
        if (state == S_CLEAR) begin
            mem[clr_cnt] <= CLEAR_VAL;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (MEM_bwe[i]) begin
                    mem[idx][i*LANE_W +: LANE_W] <= MEMin[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Array read register; samples the pre-write word so collisions read old data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= {DATA_W{1'b0}};
        end else begin
            s1_valid <= rd_acc;
            s1_err   <= rd_acc && !in_range;
            if (rd_acc) begin
                s1_data <= in_range ? mem[idx] : {DATA_W{1'b0}};
            end
        end
    end

    tsoc_mem_rdpipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rdpipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_err    (s1_err),
        .in_data   (s1_data),
        .in_wo_err (wo_oor),
        .out_valid (MEM_valid),
        .out_err   (MEM_err),
        .out_data  (MEMout)
    );

endmodule
